// File: rtl/pe_pkg.sv
// Opcode and parameter-set definitions shared by the PE array and its sequencer.
package pe_pkg;

  typedef enum logic [4:0] {
    MADD   = 5'd0,
    MSUB   = 5'd1,
    MMUL   = 5'd2,
    MMAC   = 5'd3,
    KADD   = 5'd4,
    KSUB   = 5'd5,
    KMUL   = 5'd6,
    KMAC   = 5'd7,
    CT_BFO = 5'd8,
    GS_BFO = 5'd9,
    CHKZ   = 5'd10,
    CMPEQ  = 5'd11
  } pe_instr_t;

  typedef enum logic [4:0] {
    KEM_512  = 5'd0,
    KEM_768  = 5'd1,
    KEM_1024 = 5'd2,
    DSA_44   = 5'd3,
    DSA_65   = 5'd4,
    DSA_87   = 5'd5
  } pe_alg_t;

  // Multiplier-based ops take the long PE pipeline; everything else uses the short one.
  function automatic logic pe_is_mul(pe_instr_t instr);
    case (instr)
      MMUL, MMAC, KMUL, KMAC, CT_BFO, GS_BFO: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Command, RAM-read, PE-drive and write-back signals between decoder, sequencer and PE array.
interface pe_seq_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  import pe_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  pe_instr_t         cmd_instr;
  pe_alg_t           cmd_alg;
  logic [ADDR_W-1:0] cmd_src0;
  logic [ADDR_W-1:0] cmd_src1;
  logic [ADDR_W-1:0] cmd_dst;
  logic [LEN_W-1:0]  cmd_len;
  logic              hold;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  pe_instr_t         pe_instr;
  pe_alg_t           pe_alg;
  logic              pe_in_vld;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_instr, cmd_alg, cmd_src0, cmd_src1, cmd_dst, cmd_len, hold,
    input  cmd_ready, rd_en, rd_addr0, rd_addr1, pe_instr, pe_alg, pe_in_vld,
           wr_en, wr_addr, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_instr, cmd_alg, cmd_src0, cmd_src1, cmd_dst, cmd_len, hold,
    output cmd_ready, rd_en, rd_addr0, rd_addr1, pe_instr, pe_alg, pe_in_vld,
           wr_en, wr_addr, busy, done
  );

endinterface

// File: rtl/pe_vld_pipe.sv
// Valid shift register that tracks beats through RAM read latency and PE latency.
module pe_vld_pipe #(
  parameter int RD_LAT  = 1,
  parameter int LAT_ADD = 1,
  parameter int LAT_MUL = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_vld,
  input  logic use_mul,
  input  logic flush,
  output logic pe_in_vld,
  output logic wr_en,
  output logic empty
);
  localparam int DEPTH   = RD_LAT + LAT_MUL;
  localparam int TAP_ADD = RD_LAT + LAT_ADD - 1;
  localparam int TAP_MUL = DEPTH - 1;
  localparam logic [DEPTH-1:0] MASK_ADD = {DEPTH{1'b1}} >> (DEPTH - TAP_ADD);
  localparam logic [DEPTH-1:0] MASK_MUL = {DEPTH{1'b1}} >> (DEPTH - TAP_MUL);

  logic [DEPTH-1:0] vld_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld_sr <= '0;
    else if (flush) vld_sr <= '0;
    else            vld_sr <= {vld_sr[DEPTH-2:0], in_vld};
  end

  assign pe_in_vld = vld_sr[RD_LAT-1];
  assign wr_en     = use_mul ? vld_sr[TAP_MUL] : vld_sr[TAP_ADD];

  // Only stages upstream of the active write tap can still produce a write-back.
  assign empty = !in_vld && ((vld_sr & (use_mul ? MASK_MUL : MASK_ADD)) == '0);

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequences one vector command onto the PE array: operand reads, steady opcode,
// and latency-aligned write-backs to the destination region.
module pe_seq_ctrl
  import pe_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 8,
  parameter int RD_LAT  = 1,
  parameter int LAT_ADD = 1,
  parameter int LAT_MUL = 3
) (
  input logic          clk,
  input logic          rst_n,
  pe_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [LEN_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] rd_ptr0;
  logic [ADDR_W-1:0] rd_ptr1;
  logic [ADDR_W-1:0] wr_ptr;
  pe_instr_t         instr_q;
  pe_alg_t           alg_q;
  logic              use_mul;
  logic              accept;
  logic              issue;
  logic              wr_fire;
  logic              pipe_empty;

  assign accept = (state == IDLE) && bus.cmd_valid;
  assign issue  = (state == ISSUE) && !bus.hold;

  // A zero-length command still passes through DRAIN, which exits at once on an empty pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= (bus.cmd_len == '0) ? DRAIN : ISSUE;
        ISSUE:   if (issue && beat_cnt == LEN_W'(1)) state <= DRAIN;
        DRAIN:   if (pipe_empty) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= MADD;
      alg_q   <= KEM_512;
      use_mul <= 1'b0;
    end else if (accept) begin
      instr_q <= bus.cmd_instr;
      alg_q   <= bus.cmd_alg;
      use_mul <= pe_is_mul(bus.cmd_instr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      rd_ptr0  <= '0;
      rd_ptr1  <= '0;
    end else if (accept) begin
      beat_cnt <= bus.cmd_len;
      rd_ptr0  <= bus.cmd_src0;
      rd_ptr1  <= bus.cmd_src1;
    end else if (issue) begin
      beat_cnt <= beat_cnt - LEN_W'(1);
      rd_ptr0  <= rd_ptr0 + ADDR_W'(1);
      rd_ptr1  <= rd_ptr1 + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wr_ptr <= '0;
    else if (accept)  wr_ptr <= bus.cmd_dst;
    else if (wr_fire) wr_ptr <= wr_ptr + ADDR_W'(1);
  end

  pe_vld_pipe #(
    .RD_LAT  (RD_LAT),
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL)
  ) u_vld_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (issue),
    .use_mul   (use_mul),
    .flush     (state == DONE),
    .pe_in_vld (bus.pe_in_vld),
    .wr_en     (wr_fire),
    .empty     (pipe_empty)
  );

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.rd_en     = issue;
  assign bus.rd_addr0  = rd_ptr0;
  assign bus.rd_addr1  = rd_ptr1;
  assign bus.pe_instr  = instr_q;
  assign bus.pe_alg    = alg_q;
  assign bus.wr_en     = wr_fire;
  assign bus.wr_addr   = wr_ptr;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl: stimulus queues expected beats, a negedge monitor checks them.
module tb_pe_seq_ctrl;
  import pe_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int LEN_W   = 8;
  localparam int RD_LAT  = 1;
  localparam int LAT_ADD = 1;
  localparam int LAT_MUL = 3;
  localparam int BOUND   = 600;

  typedef struct {
    pe_instr_t instr;
    pe_alg_t   alg;
    int        len;
    int        lat;
  } cmd_t;

  typedef struct {
    logic [7:0] a0;
    logic [7:0] a1;
  } rd_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  cmd_t       cmd_q[$];
  rd_t        rd_q[$];
  logic [7:0] wr_q[$];
  int         pv_t[$];
  int         wr_t[$];

  bit   m_active   = 1'b0;
  bit   in_reset   = 1'b0;
  int   beats_left = 0;
  int   exp_done   = -1;
  cmd_t cur;

  pe_seq_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  pe_seq_ctrl #(
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .RD_LAT  (RD_LAT),
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_lat(input pe_instr_t instr);
    return (instr inside {MMUL, MMAC, KMUL, KMAC, CT_BFO, GS_BFO}) ? LAT_MUL : LAT_ADD;
  endfunction

  task automatic check_output(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic randomize_fields();
    bus.cmd_instr = pe_instr_t'(5'($urandom_range(0, 11)));
    bus.cmd_alg   = pe_alg_t'(5'($urandom_range(0, 5)));
    bus.cmd_src0  = 8'($urandom);
    bus.cmd_src1  = 8'($urandom);
    bus.cmd_dst   = 8'($urandom);
    bus.cmd_len   = 8'($urandom);
  endtask

  // Monitor: every beat of a command reads src+k, and writes dst+k exactly RD_LAT+lat later.
  always @(negedge clk) begin : monitor
    bit   was_active;
    bit   exp_rd;
    bit   exp_pv;
    bit   exp_wr;
    bit   exp_dn;
    rd_t  r;
    logic [7:0] wa;
    if (!rst_n) begin
      if (!in_reset) begin
        check_output("rst_cmd_ready", bus.cmd_ready, 1);
        check_output("rst_busy",      bus.busy,      0);
        check_output("rst_rd_en",     bus.rd_en,     0);
        check_output("rst_rd_addr0",  bus.rd_addr0,  0);
        check_output("rst_rd_addr1",  bus.rd_addr1,  0);
        check_output("rst_pe_instr",  bus.pe_instr,  0);
        check_output("rst_pe_alg",    bus.pe_alg,    0);
        check_output("rst_pe_in_vld", bus.pe_in_vld, 0);
        check_output("rst_wr_en",     bus.wr_en,     0);
        check_output("rst_wr_addr",   bus.wr_addr,   0);
        check_output("rst_done",      bus.done,      0);
      end
      in_reset   = 1'b1;
      m_active   = 1'b0;
      beats_left = 0;
      exp_done   = -1;
      cmd_q.delete();
      rd_q.delete();
      wr_q.delete();
      pv_t.delete();
      wr_t.delete();
    end else begin
      in_reset   = 1'b0;
      was_active = m_active;
      check_output("cmd_ready", bus.cmd_ready, !was_active);
      check_output("busy", bus.busy, was_active);
      if (was_active) begin
        check_output("pe_instr", bus.pe_instr, cur.instr);
        check_output("pe_alg", bus.pe_alg, cur.alg);
      end

      exp_rd = was_active && (beats_left > 0) && !bus.hold;
      if (exp_rd || bus.rd_en) check_output("rd_en", bus.rd_en, exp_rd);
      if (exp_rd && rd_q.size() != 0) begin
        r = rd_q.pop_front();
        check_output("rd_addr0", bus.rd_addr0, r.a0);
        check_output("rd_addr1", bus.rd_addr1, r.a1);
        pv_t.push_back(cyc + RD_LAT);
        wr_t.push_back(cyc + RD_LAT + cur.lat);
        beats_left--;
        if (beats_left == 0) exp_done = cyc + RD_LAT + cur.lat + 1;
      end

      exp_pv = (pv_t.size() != 0) && (pv_t[0] == cyc);
      if (exp_pv) void'(pv_t.pop_front());
      if (exp_pv || bus.pe_in_vld) check_output("pe_in_vld", bus.pe_in_vld, exp_pv);

      exp_wr = (wr_t.size() != 0) && (wr_t[0] == cyc);
      if (exp_wr || bus.wr_en) check_output("wr_en", bus.wr_en, exp_wr);
      if (exp_wr && wr_q.size() != 0) begin
        void'(wr_t.pop_front());
        wa = wr_q.pop_front();
        check_output("wr_addr", bus.wr_addr, wa);
      end

      exp_dn = was_active && (cyc == exp_done);
      if (exp_dn || bus.done) check_output("done", bus.done, exp_dn);
      if (exp_dn) m_active = 1'b0;

      if (!was_active && bus.cmd_valid && cmd_q.size() != 0) begin
        cur        = cmd_q.pop_front();
        m_active   = 1'b1;
        beats_left = cur.len;
        exp_done   = (cur.len == 0) ? cyc + 2 : -1;
      end
    end
  end

  // Offers one command, then drives hold, busy-time junk commands and an optional reset pulse.
  task automatic apply_stimulus(input pe_instr_t instr, input pe_alg_t alg,
                                input logic [7:0] s0, input logic [7:0] s1,
                                input logic [7:0] d, input int len,
                                input bit hold_rand, input logic [63:0] hold_mask,
                                input int rst_at);
    cmd_t c;
    bit   finished;
    c.instr = instr;
    c.alg   = alg;
    c.len   = len;
    c.lat   = ref_lat(instr);
    for (int k = 0; k < len; k++) begin
      rd_q.push_back('{a0: s0 + 8'(k), a1: s1 + 8'(k)});
      wr_q.push_back(d + 8'(k));
    end
    cmd_q.push_back(c);

    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_instr = instr;
    bus.cmd_alg   = alg;
    bus.cmd_src0  = s0;
    bus.cmd_src1  = s1;
    bus.cmd_dst   = d;
    bus.cmd_len   = 8'(len);
    bus.hold      = hold_rand ? ($urandom_range(0, 3) == 0) : hold_mask[0];

    finished = 1'b0;
    for (int i = 1; i <= BOUND && !finished; i++) begin
      @(posedge clk);
      #1;
      if (i == rst_at)     rst_n = 1'b0;
      if (i == rst_at + 2) rst_n = 1'b1;
      bus.hold = hold_rand ? ($urandom_range(0, 3) == 0) : ((i < 64) && hold_mask[i[5:0]]);
      randomize_fields();
      bus.cmd_valid = (i <= len) && (rst_at == 0 || i < rst_at) && ($urandom_range(0, 3) == 0);
      if (!m_active && rst_n) finished = 1'b1;
    end
    check_output("cmd_complete", finished, 1);
    bus.cmd_valid = 1'b0;
    bus.hold      = 1'b0;
  endtask

  initial begin
    int len;
    bus.cmd_valid = 1'b0;
    bus.hold      = 1'b0;
    randomize_fields();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] directed commands");
    apply_stimulus(MADD, KEM_512,  8'h10, 8'h20, 8'h30, 4,   1'b0, 64'h0, 0);
    apply_stimulus(MMUL, KEM_768,  8'h50, 8'h60, 8'h40, 2,   1'b0, 64'h0, 0);
    apply_stimulus(CHKZ, DSA_44,   8'h11, 8'h22, 8'h33, 0,   1'b0, 64'h0, 0);
    apply_stimulus(MADD, KEM_1024, 8'h00, 8'h80, 8'hA0, 3,   1'b0, 64'h4, 0);
    apply_stimulus(MSUB, DSA_65,   8'hFE, 8'h7E, 8'hFD, 4,   1'b0, 64'h0, 0);
    apply_stimulus(KMUL, DSA_87,   8'h05, 8'h15, 8'h25, 4,   1'b0, 64'h0, 3);
    apply_stimulus(MADD, KEM_512,  8'h70, 8'h71, 8'h72, 5,   1'b0, 64'h0, 0);
    apply_stimulus(MMAC, KEM_768,  8'h01, 8'h02, 8'h03, 255, 1'b0, 64'h0, 0);

    $display("[TB] randomized commands");
    repeat (40) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
      apply_stimulus(pe_instr_t'(5'($urandom_range(0, 11))), pe_alg_t'(5'($urandom_range(0, 5))),
                     8'($urandom), 8'($urandom), 8'($urandom), len, 1'b1, 64'h0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
